player_input_decoder: RTL and testbench

PLAYER_INPUT_DECODER -- requirements
Module: player_input_decoder

---
 rtl/player_input_decoder.sv | 156 +++++++++++++++
 tb/tb_player_input_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_input_decoder.sv
// PS/2 keyboard receiver and key decoder for two players.
// Raw PS/2 clock/data are synchronized into Clk, frames are shifted in on
// PS/2 clock falling edges, checked for start/stop/odd parity, and accepted
// bytes drive break/extended prefix handling and six held key levels.
//
// state | meaning
// IDLE  | waiting for a start bit (falling edge with data low)
// SHIFT | receiving d0..d7, parity, stop; abandoned after an idle timeout
module player_input_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       fireboy_jump,
  output logic       fireboy_left,
  output logic       fireboy_right,
  output logic       icegirl_jump,
  output logic       icegirl_left,
  output logic       icegirl_right,
  output logic       byte_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    clk_sync;   // [1:0] synchronizer, [2] previous synced value
  logic [1:0]    data_sync;
  logic [0:0]    state;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] idle_cnt;
  logic [8:0]    shift_reg;  // {parity, d7..d0} once full
  logic          break_pending;
  logic          ext_pending;

  logic       fall;
  logic       data_bit;
  logic       stop_edge;
  logic       frame_ok;
  logic [7:0] rx_byte;

  assign fall      = clk_sync[2] & ~clk_sync[1];
  assign data_bit  = data_sync[1];
  assign stop_edge = (state == SHIFT) && fall && (bit_cnt == 4'd10);
  // start is known to be 0 because SHIFT is only entered on a low start bit
  assign frame_ok  = data_bit && (^shift_reg);
  assign rx_byte   = shift_reg[7:0];

  // Two-flop synchronizers plus one extra clock flop for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Frame receiver: bit counting, LSB-first shifting and idle timeout.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      idle_cnt  <= '0;
      shift_reg <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (fall && !data_bit) begin
            state   <= SHIFT;
            bit_cnt <= 4'd1;
          end
        end
        default: begin
          if (fall) begin
            idle_cnt <= '0;
            if (bit_cnt == 4'd10) begin
              state   <= IDLE;
              bit_cnt <= 4'd0;
            end else begin
              shift_reg <= {data_bit, shift_reg[8:1]};
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end else if (idle_cnt == IDLE_LIMIT) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Frame result pulses, scan code register and key-level decoding.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      byte_valid    <= 1'b0;
      frame_err     <= 1'b0;
      scan_code     <= 8'h00;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      fireboy_jump  <= 1'b0;
      fireboy_left  <= 1'b0;
      fireboy_right <= 1'b0;
      icegirl_jump  <= 1'b0;
      icegirl_left  <= 1'b0;
      icegirl_right <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (stop_edge) begin
        if (frame_ok) begin
          byte_valid <= 1'b1;
          scan_code  <= rx_byte;
          if (rx_byte == 8'hF0) begin
            break_pending <= 1'b1;
          end else if (rx_byte == 8'hE0) begin
            ext_pending <= 1'b1;
          end else begin
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            if (ext_pending) begin
              case (rx_byte)
                8'h75:   fireboy_jump  <= ~break_pending;
                8'h6B:   fireboy_left  <= ~break_pending;
                8'h74:   fireboy_right <= ~break_pending;
                default: ;
              endcase
            end else begin
              case (rx_byte)
                8'h1D:   icegirl_jump  <= ~break_pending;
                8'h1C:   icegirl_left  <= ~break_pending;
                8'h23:   icegirl_right <= ~break_pending;
                default: ;
              endcase
            end
          end
        end else begin
          frame_err     <= 1'b1;
          break_pending <= 1'b0;
          ext_pending   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_player_input_decoder.sv
// Self-checking bench for player_input_decoder: PS/2 frames are bit-banged
// onto ps2_clk/ps2_data and the outputs are compared with a keyboard model.
module tb_player_input_decoder;

  localparam int TO   = 200;
  localparam int HALF = 10;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       fireboy_jump, fireboy_left, fireboy_right;
  logic       icegirl_jump, icegirl_left, icegirl_right;
  logic       byte_valid, frame_err;
  logic [7:0] scan_code;

  player_input_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .fireboy_jump(fireboy_jump), .fireboy_left(fireboy_left),
    .fireboy_right(fireboy_right), .icegirl_jump(icegirl_jump),
    .icegirl_left(icegirl_left), .icegirl_right(icegirl_right),
    .byte_valid(byte_valid), .scan_code(scan_code), .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int bv_count = 0;
  int fe_count = 0;

  always @(negedge Clk) begin
    if (byte_valid) bv_count++;
    if (frame_err) fe_count++;
  end

  // keyboard model: bit0 fireboy_jump .. bit5 icegirl_right
  logic       m_brk, m_ext;
  logic [5:0] m_keys;
  logic [7:0] m_sc;

  function automatic logic [5:0] dut_keys();
    return {icegirl_right, icegirl_left, icegirl_jump,
            fireboy_right, fireboy_left, fireboy_jump};
  endfunction

  function automatic int key_idx(input logic ext, input logic [7:0] c);
    logic [7:0] ext_codes [3] = '{8'h75, 8'h6B, 8'h74};
    logic [7:0] std_codes [3] = '{8'h1D, 8'h1C, 8'h23};
    for (int k = 0; k < 3; k++) begin
      if (ext && c == ext_codes[k]) return k;
      if (!ext && c == std_codes[k]) return k + 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_keys = 6'd0; m_sc = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    int idx;
    if (!good) begin
      m_brk = 0; m_ext = 0;
    end else begin
      m_sc = b;
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else begin
        idx = key_idx(m_ext, b);
        if (idx >= 0) m_keys[idx] = !m_brk;
        m_brk = 0; m_ext = 0;
      end
    end
  endtask

  // Drive the first n bits of a frame; for a full frame, check the
  // result pulses and key levels around the stop-bit edge.
  task automatic drive_bits(input logic [10:0] bits, input int n, input bit good,
                            input logic [5:0] old_keys, input string name);
    logic [1:0] got, exp;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      ps2_data = bits[i];
      repeat (HALF) @(negedge Clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        for (int j = 1; j <= 4; j++) begin
          @(posedge Clk); #1;
          got = {byte_valid, frame_err};
          exp = (j == 3) ? (good ? 2'b10 : 2'b01) : 2'b00;
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL %s pulse cyc%0d: {bv,fe}=%b required %b", name, j, got, exp);
          end
          if (j == 2) begin
            checks++;
            if (dut_keys() !== old_keys) begin
              errors++;
              $display("FAIL %s keys early: got %b required %b", name, dut_keys(), old_keys);
            end
          end
          if (j == 3) begin
            checks++;
            if (dut_keys() !== m_keys) begin
              errors++;
              $display("FAIL %s keys: got %b required %b", name, dut_keys(), m_keys);
            end
            checks++;
            if (scan_code !== m_sc) begin
              errors++;
              $display("FAIL %s scan_code: got %h required %h", name, scan_code, m_sc);
            end
          end
        end
        repeat (HALF - 3) @(negedge Clk);
      end else begin
        repeat (HALF) @(negedge Clk);
      end
      ps2_clk = 1'b1;
    end
    @(negedge Clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge Clk);
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input bit good);
    logic par;
    par = good ? ~(^b) : (^b);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit good, input string name);
    logic [5:0] old;
    old = m_keys;
    model_byte(b, good);
    drive_bits(frame_of(b, good), 11, good, old, name);
  endtask

  task automatic check_delta(input int bv0, input int fe0, input int bv_exp,
                             input int fe_exp, input string name);
    checks++;
    if (bv_count - bv0 !== bv_exp || fe_count - fe0 !== fe_exp) begin
      errors++;
      $display("FAIL %s counts: bv=%0d fe=%0d required bv=%0d fe=%0d",
               name, bv_count - bv0, fe_count - fe0, bv_exp, fe_exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (dut_keys() !== 6'd0 || byte_valid !== 1'b0 || frame_err !== 1'b0 ||
        scan_code !== 8'h00) begin
      errors++;
      $display("FAIL %s: keys=%b bv=%b fe=%b sc=%h required all 0",
               name, dut_keys(), byte_valid, frame_err, scan_code);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check_all_zero("reset_held");
    Reset = 1'b0;
    model_reset();
    repeat (5) @(negedge Clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_basic();
    int bv0 = bv_count, fe0 = fe_count;
    send_frame(8'h1D, 1, "basic_1D");
    check_delta(bv0, fe0, 1, 0, "basic_1D");
  endtask

  task automatic test_extended();
    int bv0 = bv_count, fe0 = fe_count;
    send_frame(8'hE0, 1, "ext_E0a");
    send_frame(8'h6B, 1, "ext_6B_make");
    send_frame(8'hE0, 1, "ext_E0b");
    send_frame(8'hF0, 1, "ext_F0");
    send_frame(8'h6B, 1, "ext_6B_break");
    check_delta(bv0, fe0, 5, 0, "ext_seq");
  endtask

  task automatic test_bad_parity();
    int bv0 = bv_count, fe0 = fe_count;
    send_frame(8'h1C, 0, "bad_parity_1C");
    check_delta(bv0, fe0, 0, 1, "bad_parity_1C");
  endtask

  task automatic test_timeout();
    int bv0 = bv_count, fe0 = fe_count;
    drive_bits(frame_of(8'h5A, 1), 4, 1, m_keys, "timeout_partial");
    repeat (TO + 10) @(negedge Clk);
    check_delta(bv0, fe0, 0, 0, "timeout_gap");
    send_frame(8'h23, 1, "timeout_23");
    check_delta(bv0, fe0, 1, 0, "timeout_total");
  endtask

  task automatic test_hold();
    send_frame(8'h1C, 1, "hold_1C");
    send_frame(8'h23, 1, "hold_23");
    send_frame(8'hF0, 1, "hold_F0");
    send_frame(8'h1C, 1, "hold_1C_break");
    send_frame(8'h29, 1, "hold_29");
    send_frame(8'h1C, 1, "typematic_1");
    send_frame(8'h1C, 1, "typematic_2");
    send_frame(8'hF0, 1, "idle_break_F0");
    send_frame(8'h1D, 1, "idle_break_1D");
  endtask

  task automatic test_reset_midframe();
    send_frame(8'hE0, 1, "mid_pre_E0");
    send_frame(8'h74, 1, "mid_pre_74");
    drive_bits(frame_of(8'h75, 1), 6, 1, m_keys, "mid_partial");
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
    check_all_zero("mid_reset");
    send_frame(8'hE0, 1, "mid_post_E0");
    send_frame(8'h74, 1, "mid_post_74");
  endtask

  task automatic test_random();
    logic [7:0] pool [10] = '{8'hF0, 8'hE0, 8'h75, 8'h6B, 8'h74,
                              8'h1D, 8'h1C, 8'h23, 8'h29, 8'h00};
    logic [7:0] b;
    bit good;
    for (int n = 0; n < 40; n++) begin
      b = pool[$urandom_range(0, 9)];
      if (b == 8'h00) b = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_frame(b, good, "random");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_extended();
    test_bad_parity();
    test_timeout();
    test_hold();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
